// File: rtl/amber_wb_responder.sv
// Wishbone classic responder for the amber 128-bit master: byte-maskable RAM,
// a 128-bit Fibonacci LFSR read port, and an error region, with fixed wait states.
module amber_wb_responder #(
    parameter int unsigned  DEPTH       = 16,
    parameter int unsigned  WAIT_CYCLES = 2,
    parameter logic [127:0] SEED        = 128'h1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  i_wb_adr,
    input  logic [15:0]  i_wb_sel,
    input  logic         i_wb_we,
    input  logic [127:0] i_wb_dat,
    input  logic         i_wb_cyc,
    input  logic         i_wb_stb,
    output logic [127:0] o_wb_dat,
    output logic         o_wb_ack,
    output logic         o_wb_err
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] RAM_LIMIT = 32'(DEPTH * 16);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_adr;
    logic [15:0]   r_sel;
    logic          r_we;
    logic [127:0]  r_dat;
    logic [127:0]  r_lfsr;
    logic [127:0]  r_mem [DEPTH];

    logic          w_req;
    logic          w_is_ram;
    logic          w_is_rnd;
    logic [AW-1:0] w_idx;
    logic [127:0]  w_lfsr_next;

    assign w_req       = i_wb_cyc & i_wb_stb;
    assign w_is_ram    = (r_adr < RAM_LIMIT);
    assign w_is_rnd    = (r_adr[31:28] == 4'hF);
    assign w_idx       = r_adr[AW+3:4];
    assign w_lfsr_next = {r_lfsr[126:0], r_lfsr[127] ^ r_lfsr[126] ^ r_lfsr[125] ^ r_lfsr[120]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_adr    <= '0;
            r_sel    <= '0;
            r_we     <= 1'b0;
            r_dat    <= '0;
            r_lfsr   <= SEED;
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[AW'(i)] <= '0;
            end
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_adr   <= i_wb_adr;
                        r_sel   <= i_wb_sel;
                        r_we    <= i_wb_we;
                        r_dat   <= i_wb_dat;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A dropped request abandons the transfer before any side effect.
                    if (!w_req) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                        if (r_cnt == 4'd1) begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    if (w_is_ram) begin
                        o_wb_ack <= 1'b1;
                        if (r_we) begin
                            for (int unsigned k = 0; k < 16; k++) begin
                                if (r_sel[k]) begin
                                    r_mem[w_idx][8*k +: 8] <= r_dat[8*k +: 8];
                                end
                            end
                        end else begin
                            o_wb_dat <= r_mem[w_idx];
                        end
                    end else if (w_is_rnd) begin
                        o_wb_ack <= 1'b1;
                        if (!r_we) begin
                            o_wb_dat <= r_lfsr;
                            r_lfsr   <= w_lfsr_next;
                        end
                    end else begin
                        o_wb_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amber_wb_responder.sv
// Directed bench for amber_wb_responder: default-parameter instance for RAM, LFSR,
// error, abort and reset cases, plus a zero-wait instance for back-to-back timing.
module tb_amber_wb_responder;

    logic         clk = 1'b0;
    logic         reset;

    logic [31:0]  adr;
    logic [15:0]  sel;
    logic         we;
    logic [127:0] wdat;
    logic         cyc;
    logic         stb;
    logic [127:0] rdat;
    logic         ack;
    logic         err;

    logic [31:0]  adr0;
    logic [15:0]  sel0;
    logic         we0;
    logic [127:0] wdat0;
    logic         cyc0;
    logic         stb0;
    logic [127:0] rdat0;
    logic         ack0;
    logic         err0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    amber_wb_responder #(.DEPTH(16), .WAIT_CYCLES(2), .SEED(128'h1)) u_dut (
        .clk(clk), .reset(reset),
        .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we), .i_wb_dat(wdat),
        .i_wb_cyc(cyc), .i_wb_stb(stb),
        .o_wb_dat(rdat), .o_wb_ack(ack), .o_wb_err(err)
    );

    amber_wb_responder #(.DEPTH(16), .WAIT_CYCLES(0), .SEED(128'h1)) u_dut0 (
        .clk(clk), .reset(reset),
        .i_wb_adr(adr0), .i_wb_sel(sel0), .i_wb_we(we0), .i_wb_dat(wdat0),
        .i_wb_cyc(cyc0), .i_wb_stb(stb0),
        .o_wb_dat(rdat0), .o_wb_ack(ack0), .o_wb_err(err0)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer; lat counts edges after the sampling edge (0 = timeout).
    task automatic xfer(input logic [31:0] a, input logic [15:0] s, input logic w,
                        input logic [127:0] d, output int lat, output logic r_ack,
                        output logic r_err, output logic [127:0] r_dat,
                        output logic n_ack, output logic n_err, output logic [127:0] n_dat);
        adr = a; sel = s; we = w; wdat = d; cyc = 1'b1; stb = 1'b1;
        lat = 0; r_ack = 1'b0; r_err = 1'b0; r_dat = '0;
        tick();
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (ack || err) begin
                lat = n; r_ack = ack; r_err = err; r_dat = rdat;
                break;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        n_ack = ack; n_err = err; n_dat = rdat;
    endtask

    int           lat;
    logic         a1, e1, a2, e2, seen;
    logic [127:0] d1, d2;

    initial begin
        reset = 1'b1;
        adr = '0; sel = '0; we = 1'b0; wdat = '0; cyc = 1'b0; stb = 1'b0;
        adr0 = '0; sel0 = '0; we0 = 1'b0; wdat0 = '0; cyc0 = 1'b0; stb0 = 1'b0;
        repeat (3) tick();
        check("reset_ack", 128'(ack), 128'(1'b0));
        check("reset_err", 128'(err), 128'(1'b0));
        check("reset_dat", rdat, 128'h0);
        reset = 1'b0;
        tick();

        xfer(32'h10, 16'hFFFF, 1'b1, {16{8'hA5}}, lat, a1, e1, d1, a2, e2, d2);
        check("wr_latency", 128'(lat), 128'(3));
        check("wr_ack", 128'(a1), 128'(1'b1));
        check("wr_err", 128'(e1), 128'(1'b0));
        check("wr_ack_one_cycle", 128'(a2), 128'(1'b0));

        xfer(32'h10, 16'h0000, 1'b0, 128'h0, lat, a1, e1, d1, a2, e2, d2);
        check("rd_latency", 128'(lat), 128'(3));
        check("rd_data", d1, {16{8'hA5}});
        check("rd_dat_after", d2, 128'h0);

        xfer(32'h0, 16'h0001, 1'b1, '1, lat, a1, e1, d1, a2, e2, d2);
        xfer(32'h0, 16'h0000, 1'b0, 128'h0, lat, a1, e1, d1, a2, e2, d2);
        check("byte0_only", d1, 128'hFF);

        xfer(32'hF000_0000, 16'h0, 1'b0, 128'h0, lat, a1, e1, d1, a2, e2, d2);
        check("rnd_first", d1, 128'h1);
        check("rnd_first_ack", 128'(a1), 128'(1'b1));
        xfer(32'hF000_0000, 16'h0, 1'b0, 128'h0, lat, a1, e1, d1, a2, e2, d2);
        check("rnd_second", d1, 128'h2);
        xfer(32'hF000_0000, 16'hFFFF, 1'b1, '1, lat, a1, e1, d1, a2, e2, d2);
        check("rnd_wr_ack", 128'(a1), 128'(1'b1));
        xfer(32'hF000_0000, 16'h0, 1'b0, 128'h0, lat, a1, e1, d1, a2, e2, d2);
        check("rnd_after_wr", d1, 128'h4);

        xfer(32'h0000_1000, 16'h0, 1'b0, 128'h0, lat, a1, e1, d1, a2, e2, d2);
        check("err_latency", 128'(lat), 128'(3));
        check("err_err", 128'(e1), 128'(1'b1));
        check("err_ack", 128'(a1), 128'(1'b0));
        check("err_dat", d1, 128'h0);
        check("err_one_cycle", 128'(e2), 128'(1'b0));

        // Write to word 2 aborted while waiting.
        adr = 32'h20; sel = 16'hFFFF; we = 1'b1; wdat = 128'h1234; cyc = 1'b1; stb = 1'b1;
        tick();
        stb = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (ack || err) seen = 1'b1;
        end
        cyc = 1'b0; we = 1'b0;
        check("abort_no_resp", 128'(seen), 128'(1'b0));
        xfer(32'h20, 16'h0, 1'b0, 128'h0, lat, a1, e1, d1, a2, e2, d2);
        check("abort_ram_unchanged", d1, 128'h0);

        // Write to word 3 hit by reset while in RESP.
        adr = 32'h30; sel = 16'hFFFF; we = 1'b1; wdat = 128'h5678; cyc = 1'b1; stb = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        check("rst_resp_ack", 128'(ack), 128'(1'b0));
        check("rst_resp_err", 128'(err), 128'(1'b0));
        reset = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (ack || err) seen = 1'b1;
        end
        check("rst_no_resp", 128'(seen), 128'(1'b0));
        xfer(32'h30, 16'h0, 1'b0, 128'h0, lat, a1, e1, d1, a2, e2, d2);
        check("rst_not_committed", d1, 128'h0);
        xfer(32'h10, 16'h0, 1'b0, 128'h0, lat, a1, e1, d1, a2, e2, d2);
        check("rst_ram_cleared", d1, 128'h0);
        xfer(32'hF000_0000, 16'h0, 1'b0, 128'h0, lat, a1, e1, d1, a2, e2, d2);
        check("rst_lfsr_seed", d1, 128'h1);

        // Zero-wait instance, random reads held continuously: ack every second cycle.
        adr0 = 32'hF000_0000; sel0 = '0; we0 = 1'b0; cyc0 = 1'b1; stb0 = 1'b1;
        tick();
        check("zw_ack_e0", 128'(ack0), 128'(1'b0));
        tick();
        check("zw_ack_e1", 128'(ack0), 128'(1'b1));
        check("zw_dat_e1", rdat0, 128'h1);
        tick();
        check("zw_ack_e2", 128'(ack0), 128'(1'b0));
        check("zw_dat_e2", rdat0, 128'h0);
        tick();
        check("zw_ack_e3", 128'(ack0), 128'(1'b1));
        check("zw_dat_e3", rdat0, 128'h2);
        tick();
        check("zw_ack_e4", 128'(ack0), 128'(1'b0));
        tick();
        check("zw_ack_e5", 128'(ack0), 128'(1'b1));
        check("zw_dat_e5", rdat0, 128'h4);
        check("zw_err_e5", 128'(err0), 128'(1'b0));
        cyc0 = 1'b0; stb0 = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
